// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 inverse cipher: one inverse round per clock, round keys unwound on the fly.
// Optional macro AES_INV_KEY0_OUT_EN adds key0_out (recovered cipher key).
module aes_inv_cipher_iter (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] ct_in,
    input  logic [127:0] key10_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] pt_out
`ifdef AES_INV_KEY0_OUT_EN
    ,
    output logic [127:0] key0_out
`endif
);

    localparam int unsigned BLK_W = 128;
    localparam int unsigned RND_W = 4;
    localparam logic [RND_W-1:0] NR = RND_W'(10);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [RND_W-1:0] rnd_q, rnd_d;
    logic [BLK_W-1:0] st_q, st_d;
    logic [BLK_W-1:0] key_q, key_d;
    logic [BLK_W-1:0] pt_d;
    logic             in_ready_d, out_valid_d;
    logic [BLK_W-1:0] kprev_c, round_c;
`ifdef AES_INV_KEY0_OUT_EN
    logic [BLK_W-1:0] key0_d;
`endif

    // GF(2^8) arithmetic modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = '0;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = xtime(x);
        end
        return acc;
    endfunction

    // a^254 == a^-1 for a != 0, and maps 0 to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] x3, x7, x15, x31, x63, x127;
        x3   = gf_mul(gf_mul(a, a), a);
        x7   = gf_mul(gf_mul(x3, x3), a);
        x15  = gf_mul(gf_mul(x7, x7), a);
        x31  = gf_mul(gf_mul(x15, x15), a);
        x63  = gf_mul(gf_mul(x31, x31), a);
        x127 = gf_mul(gf_mul(x63, x63), a);
        return gf_mul(x127, x127);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        logic [7:0] t;
        t = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
        return gf_inv(t);
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        int r, c, src;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            r   = i % 4;
            c   = i / 4;
            src = r + 4 * ((c - r + 4) % 4);
            o[127-8*i -: 8] = s[127-8*src -: 8];
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    function automatic logic [7:0] rcon(input logic [RND_W-1:0] r);
        case (r)
            4'd10:   return 8'h36;
            4'd9:    return 8'h1b;
            4'd8:    return 8'h80;
            4'd7:    return 8'h40;
            4'd6:    return 8'h20;
            4'd5:    return 8'h10;
            4'd4:    return 8'h08;
            4'd3:    return 8'h04;
            4'd2:    return 8'h02;
            4'd1:    return 8'h01;
            default: return 8'h00;
        endcase
    endfunction

    // Undo one key-expansion step: round-r key -> round-(r-1) key
    function automatic logic [127:0] inv_key_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, p0, p1, p2, p3, rot, sub;
        w0  = k[127:96];
        w1  = k[95:64];
        w2  = k[63:32];
        w3  = k[31:0];
        p3  = w3 ^ w2;
        p2  = w2 ^ w1;
        p1  = w1 ^ w0;
        rot = {p3[23:0], p3[31:24]};
        sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
        p0  = w0 ^ sub ^ {rc, 24'h0};
        return {p0, p1, p2, p3};
    endfunction

    // Round datapath shared by the middle rounds and the final round
    always_comb begin
        kprev_c = inv_key_step(key_q, rcon(rnd_q));
        round_c = inv_sub_bytes(inv_shift_rows(st_q)) ^ kprev_c;
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        st_d    = st_q;
        key_d   = key_q;
        pt_d    = pt_out;
`ifdef AES_INV_KEY0_OUT_EN
        key0_d  = key0_out;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    st_d    = ct_in ^ key10_in;
                    key_d   = key10_in;
                    rnd_d   = NR;
                    state_d = RUN;
                end
            end
            RUN: begin
                key_d = kprev_c;
                rnd_d = rnd_q - RND_W'(1);
                if (rnd_q == RND_W'(1)) begin
                    pt_d    = round_c;
`ifdef AES_INV_KEY0_OUT_EN
                    key0_d  = kprev_c;
`endif
                    state_d = DONE;
                end else begin
                    st_d = inv_mix_columns(round_c);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rnd_q     <= '0;
            st_q      <= '0;
            key_q     <= '0;
            pt_out    <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
`ifdef AES_INV_KEY0_OUT_EN
            key0_out  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            rnd_q     <= rnd_d;
            st_q      <= st_d;
            key_q     <= key_d;
            pt_out    <= pt_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
`ifdef AES_INV_KEY0_OUT_EN
            key0_out  <= key0_d;
`endif
        end
    end

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Self-checking bench for aes_inv_cipher_iter: FIPS vectors, backpressure, back-to-back,
// mid-run reset and forward-cipher loopback through a scoreboard queue.
module tb_aes_inv_cipher_iter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] ct_in = '0;
    logic [127:0] key10_in = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] pt_out;
`ifdef AES_INV_KEY0_OUT_EN
    logic [127:0] key0_out;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] sb [256];

    typedef struct {
        logic [127:0] pt;
        logic [127:0] k0;
        int           acc;
    } exp_t;
    exp_t sbq[$];

    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_K10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_K0  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_K10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_K0   = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    aes_inv_cipher_iter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ct_in     (ct_in),
        .key10_in  (key10_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pt_out    (pt_out)
`ifdef AES_INV_KEY0_OUT_EN
        ,
        .key0_out  (key0_out)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Forward AES-128 reference model (encryption side of the link)
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ 8'(p << 1) ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ 8'(q << 1);
            q = q ^ 8'(q << 2);
            q = q ^ 8'(q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
    endtask

    function automatic logic [7:0] m_xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] m_sub(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sb[s[127-8*i -: 8]];
        return o;
    endfunction

    function automatic logic [127:0] m_shift(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] m_mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = m_xt(a0) ^ (m_xt(a1) ^ a1) ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ m_xt(a1) ^ (m_xt(a2) ^ a2) ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ m_xt(a2) ^ (m_xt(a3) ^ a3);
            o[103-32*c -: 8] = (m_xt(a0) ^ a0) ^ a1 ^ a2 ^ m_xt(a3);
        end
        return o;
    endfunction

    function automatic logic [127:0] m_knext(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, n0, n1, n2, n3;
        t  = {sb[k[23:16]], sb[k[15:8]], sb[k[7:0]], sb[k[31:24]]} ^ {rc, 24'h0};
        n0 = k[127:96] ^ t;
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    task automatic encrypt(input logic [127:0] pt, input logic [127:0] key,
                           output logic [127:0] ct, output logic [127:0] k10);
        logic [127:0] s, k;
        logic [7:0]   rc;
        k  = key;
        rc = 8'h01;
        s  = pt ^ k;
        for (int r = 1; r <= 10; r++) begin
            k  = m_knext(k, rc);
            rc = m_xt(rc);
            s  = m_shift(m_sub(s));
            if (r < 10) s = m_mix(s);
            s = s ^ k;
        end
        ct  = s;
        k10 = k;
    endtask

    // Present one block; returns at the negedge just after the accept edge
    task automatic drive(input logic [127:0] ct, input logic [127:0] k10,
                         input logic [127:0] pt, input logic [127:0] k0, input bit hold);
        int w;
        @(negedge clk);
        ct_in    = ct;
        key10_in = k10;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", in_ready, w);
            in_valid = 1'b0;
            return;
        end
        sbq.push_back('{pt, k0, cyc + 1});
        @(negedge clk);
        if (!hold) in_valid = 1'b0;
    endtask

    // Wait for a result, pop the scoreboard and compare
    task automatic collect(input string name, output int t_out);
        exp_t e;
        int   w;
        t_out = -1;
        @(negedge clk);
        w = 0;
        while (!out_valid && w < 200) begin
            @(negedge clk);
            w++;
        end
        n_checks++;
        if (!out_valid) begin
            n_fail++;
            $display("FAIL %s_out_timeout: out_valid=%b after %0d cycles, required 1", name, out_valid, w);
            return;
        end
        if (sbq.size() == 0) begin
            n_fail++;
            $display("FAIL %s_unexpected_output: pt_out=%h with empty scoreboard", name, pt_out);
            return;
        end
        e = sbq.pop_front();
        t_out = cyc;
        n_checks++;
        if (pt_out !== e.pt) begin
            n_fail++;
            $display("FAIL %s_pt: got %h required %h", name, pt_out, e.pt);
        end
        n_checks++;
        if (cyc - e.acc !== 10) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d required 10", name, cyc - e.acc);
        end
`ifdef AES_INV_KEY0_OUT_EN
        n_checks++;
        if (key0_out !== e.k0) begin
            n_fail++;
            $display("FAIL %s_key0: got %h required %h", name, key0_out, e.k0);
        end
`endif
        if (out_ready) @(negedge clk);
    endtask

    task automatic check_idle_reset_values(input string name);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_in_ready: got %b required 1", name, in_ready);
        end
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_out_valid: got %b required 0", name, out_valid);
        end
        n_checks++;
        if (pt_out !== 128'h0) begin
            n_fail++;
            $display("FAIL %s_pt_out: got %h required 0", name, pt_out);
        end
`ifdef AES_INV_KEY0_OUT_EN
        n_checks++;
        if (key0_out !== 128'h0) begin
            n_fail++;
            $display("FAIL %s_key0_out: got %h required 0", name, key0_out);
        end
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_reset_values("reset_held");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_idle_reset_values("reset_released");
    endtask

    task automatic test_fips();
        int t;
        drive(C1_CT, C1_K10, C1_PT, C1_K0, 1'b0);
        collect("fips_c1", t);
        drive(B_CT, B_K10, B_PT, B_K0, 1'b0);
        collect("fips_appb", t);
    endtask

    task automatic test_backpressure();
        int t;
        out_ready = 1'b0;
        drive(C1_CT, C1_K10, C1_PT, C1_K0, 1'b0);
        collect("bp", t);
        for (int i = 0; i < 20; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || pt_out !== C1_PT) begin
                n_fail++;
                $display("FAIL bp_hold cycle %0d: out_valid=%b in_ready=%b pt_out=%h required 1 0 %h",
                         i, out_valid, in_ready, pt_out, C1_PT);
            end
            ct_in    = B_CT;
            key10_in = B_K10;
            in_valid = (i >= 5 && i < 12);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
        for (int i = 0; i < 14; i++) begin
            n_checks++;
            if (out_valid !== 1'b0 || pt_out !== C1_PT) begin
                n_fail++;
                $display("FAIL bp_no_capture cycle %0d: out_valid=%b pt_out=%h required 0 %h",
                         i, out_valid, pt_out, C1_PT);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        int t1, t2;
        t1 = -1;
        t2 = -1;
        fork
            begin
                drive(C1_CT, C1_K10, C1_PT, C1_K0, 1'b1);
                drive(B_CT, B_K10, B_PT, B_K0, 1'b0);
            end
            begin
                collect("b2b_first", t1);
                collect("b2b_second", t2);
            end
        join
        n_checks++;
        if (t2 - t1 !== 12) begin
            n_fail++;
            $display("FAIL b2b_interval: got %0d required 12", t2 - t1);
        end
    endtask

    task automatic test_reset_midrun();
        int t;
        drive(C1_CT, C1_K10, C1_PT, C1_K0, 1'b0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_idle_reset_values("midrun_reset");
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL midrun_discard cycle %0d: out_valid=%b required 0", i, out_valid);
            end
        end
        drive(C1_CT, C1_K10, C1_PT, C1_K0, 1'b0);
        collect("midrun_reissue", t);
    endtask

    task automatic test_loopback();
        logic [127:0] key, pt, ct, k10;
        int t;
        for (int n = 0; n < 1000; n++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            pt  = {$urandom, $urandom, $urandom, $urandom};
            encrypt(pt, key, ct, k10);
            drive(ct, k10, pt, key, 1'b0);
            collect("loopback", t);
        end
    endtask

    initial begin
        build_sbox();
        test_reset();
        test_fips();
        test_backpressure();
        test_back_to_back();
        test_reset_midrun();
        test_loopback();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_inv_cipher_iter.md
Name: aes_inv_cipher_iter

Overview:
- Iterative AES-128 decryption core: the inverse of the encryption datapath.
- Takes a ciphertext and the final (round-10) round key, and recovers the plaintext one inverse round per clock.
- Derives round keys 9..0 on the fly with the inverse key schedule, so no key RAM is needed.
- Sits on the receive side of the cipher link and consumes the ciphertext and last round key emitted by the encryption path.

Parameters:
- none (AES-128 only; Nr = 10 fixed)

Ports:
- clk        input   1    system clock, rising edge
- rst_n      input   1    asynchronous active-low reset
- in_valid   input   1    ciphertext/key presented
- in_ready   output  1    core idle, will accept
- ct_in      input   128  ciphertext, byte 0 = bits [127:120]
- key10_in   input   128  round-10 key (last key-expansion output)
- out_valid  output  1    plaintext valid
- out_ready  input   1    consumer accepts plaintext
- pt_out     output  128  plaintext, same byte order as ct_in

Behaviour:
- Reset (async assert, sync deassert in clk domain): state=IDLE, in_ready=1, out_valid=0, pt_out=0, round counter=0, state/key registers=0.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&in_ready (edge T):
  - state_reg <= ct_in ^ key10_in
  - key_reg <= key10_in
  - rnd <= 10
  - -> RUN
- RUN, each edge:
  - kprev = InvKeyStep(key_reg, Rcon[rnd]); key_reg <= kprev.
  - rnd 10..2: state_reg <= InvMixColumns(InvSubBytes(InvShiftRows(state_reg)) ^ kprev).
  - rnd 1: pt_out <= InvSubBytes(InvShiftRows(state_reg)) ^ kprev; -> DONE.
  - rnd decrements each edge.
- Rcon[rnd], rnd=10..1: 36,1b,80,40,20,10,08,04,02,01 (in the MSB of the word).
- InvKeyStep, words w0..w3 MSB-first:
  - p3 = w3^w2; p2 = w2^w1; p1 = w1^w0
  - p0 = w0 ^ SubWord(RotWord(p3)) ^ {Rcon,24'h0}
- Latency: out_valid rises after edge T+10, i.e. exactly 10 cycles from acceptance to out_valid.
- DONE: out_valid=1 and pt_out stable until out_valid&out_ready; then -> IDLE, out_valid=0. pt_out holds its last value.
- in_ready=0 in RUN and DONE; in_valid there is ignored and no data is captured.
- Back-to-back operation: no same-cycle bypass. After the out handshake edge, in_ready=1 on the next cycle, giving a minimum 12-cycle initiation interval.
- S-boxes (forward for SubWord, inverse for InvSubBytes):
  - computed arithmetically: GF(2^8) inversion mod 0x11B plus affine / inverse affine;
  - inverse of 0x00 is 0x00;
  - no 256-entry tables.
- InvMixColumns: per column, matrix {0e,0b,0d,09} over GF(2^8) mod 0x11B.
- InvShiftRows: row r rotated right by r bytes; column-major state, byte i -> row i%4, col i/4.
- Reset asserted mid-RUN/DONE: immediate return to reset values; the partial result is discarded and never presented.
- X on in_valid in IDLE is a verification error; inputs are don't-care when in_valid=0.

Optional Feature:
- Macro AES_INV_KEY0_OUT_EN.
- Defined:
  - adds output port key0_out [127:0], the recovered cipher key (round-0 key);
  - key0_out is updated on the same edge as pt_out and valid under out_valid;
  - it resets to 0.
- Undefined: port absent; key_reg after the last round is unused.
- Datapath timing is identical either way.

Test Plan:
- FIPS-197 C.1: ct=69c4e0d86a7b0430d8cdb78070b4c55a, key10=13111d7fe3944a17f307a78b4d2b30c5 -> pt_out=00112233445566778899aabbccddeeff exactly 10 cycles after accept; with the macro, key0_out=000102030405060708090a0b0c0d0e0f.
- FIPS-197 App. B: ct=3925841d02dc09fbdc118597196a0b32, key10=d014f9a8c9ee2589e13f0cc8b6630ca6 -> pt_out=3243f6a8885a308d313198a2e0370734; with the macro, key0_out=2b7e151628aed2a6abf7158809cf4f3c.
- Backpressure: out_ready=0 for 20 cycles after out_valid -> pt_out stable, out_valid held, in_ready=0, second in_valid ignored; release -> IDLE on next cycle.
- Back-to-back: C.1 then App. B vectors with in_valid held high -> both plaintexts correct; second out_valid 12 cycles after first.
- Reset at round 5 of C.1 -> out_valid=0, in_ready=1, pt_out=0 immediately; re-issue -> correct C.1 plaintext.
- Loopback: 1000 random key/pt pairs through the encryption path into this core -> pt_out equals the original plaintext every time.
